// File: rtl/grid_io_cfg_tile.sv
// grid_io_cfg_tile
//   Configurable IO tile holding NUM_IO GPIO subtiles. A serial configuration
//   chain (3 bits per subtile) selects, per subtile, the pad direction and
//   whether the input and output paths are registered. Pads stay in a safe
//   state (no output enable, no inbound data) until an exact-length
//   configuration has been shifted in and the shift enable is low again.
//
// Ports
//   clk                    : clock, all state updates on its rising edge
//   rst_n                  : synchronous active-low reset
//   cfg_en                 : configuration shift enable
//   cfg_head               : serial configuration data in
//   cfg_tail               : serial configuration data out (last chain bit)
//   cfg_done               : exact-length configuration loaded and active
//   cfg_err                : last load session shifted too many bits
//   gfpga_pad_GPIO_PAD_in  : pad receive data
//   gfpga_pad_GPIO_PAD_out : pad drive data
//   gfpga_pad_GPIO_PAD_oe  : pad output enable, active-high
//   io_outpad              : fabric-to-pad data
//   io_inpad               : pad-to-fabric data
//
// Chain layout for subtile i: [3i] oe_mode, [3i+1] in_reg, [3i+2] out_reg.
module grid_io_cfg_tile #(
  parameter int NUM_IO          = 8,
  parameter int CFG_BITS_PER_IO = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_en,
  input  logic              cfg_head,
  output logic              cfg_tail,
  output logic              cfg_done,
  output logic              cfg_err,
  input  logic [NUM_IO-1:0] gfpga_pad_GPIO_PAD_in,
  output logic [NUM_IO-1:0] gfpga_pad_GPIO_PAD_out,
  output logic [NUM_IO-1:0] gfpga_pad_GPIO_PAD_oe,
  input  logic [NUM_IO-1:0] io_outpad,
  output logic [NUM_IO-1:0] io_inpad
);

  localparam int CFG_BITS = CFG_BITS_PER_IO * NUM_IO;
  localparam int CNT_W    = $clog2(CFG_BITS + 2);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CFG_BITS-1:0] chain_q, chain_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                prev_en_q;
  logic [NUM_IO-1:0]   out_q, in_q;

  logic [NUM_IO-1:0]   oe_mode, in_reg, out_reg;

  // Shift chain and session counter next state
  always_comb begin
    chain_d = chain_q;
    cnt_d   = cnt_q;
    if (cfg_en) begin
      chain_d = {chain_q[CFG_BITS-2:0], cfg_head};
      // A rising cfg_en starts a new session; the counter restarts at 1 so
      // that a stale overflow from the previous session is forgotten.
      if (!prev_en_q) begin
        cnt_d = CNT_ONE;
      end else if (cnt_q != CNT_OVER) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain_q   <= '0;
      cnt_q     <= '0;
      prev_en_q <= 1'b0;
      out_q     <= '0;
      in_q      <= '0;
    end else begin
      chain_q   <= chain_d;
      cnt_q     <= cnt_d;
      prev_en_q <= cfg_en;
      out_q     <= io_outpad;
      in_q      <= gfpga_pad_GPIO_PAD_in;
    end
  end

  // cfg_done is combinational on cfg_en so the pads fall back to the safe
  // state in the very cycle a reload begins.
  assign cfg_tail = chain_q[CFG_BITS-1];
  assign cfg_done = !cfg_en && (cnt_q == CNT_FULL);
  assign cfg_err  = (cnt_q == CNT_OVER);

  always_comb begin
    oe_mode = '0;
    in_reg  = '0;
    out_reg = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      oe_mode[i] = chain_q[CFG_BITS_PER_IO*i];
      in_reg[i]  = chain_q[CFG_BITS_PER_IO*i + 1];
      out_reg[i] = chain_q[CFG_BITS_PER_IO*i + 2];
    end
  end

  // Pad drive data is not gated by cfg_done: with oe low it never reaches
  // the pin, and keeping it ungated preserves the registered-path latency.
  always_comb begin
    gfpga_pad_GPIO_PAD_out = '0;
    gfpga_pad_GPIO_PAD_oe  = '0;
    io_inpad               = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      gfpga_pad_GPIO_PAD_out[i] = out_reg[i] ? out_q[i] : io_outpad[i];
      gfpga_pad_GPIO_PAD_oe[i]  = cfg_done & oe_mode[i];
      io_inpad[i]               = cfg_done & ~oe_mode[i] &
                                  (in_reg[i] ? in_q[i] : gfpga_pad_GPIO_PAD_in[i]);
    end
  end

endmodule

// File: tb/tb_grid_io_cfg_tile.sv
module tb_grid_io_cfg_tile;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_en;
  logic       cfg_head;
  logic       cfg_tail;
  logic       cfg_done;
  logic       cfg_err;
  logic [7:0] pad_in;
  logic [7:0] pad_out;
  logic [7:0] pad_oe;
  logic [7:0] io_outpad;
  logic [7:0] io_inpad;

  grid_io_cfg_tile #(.NUM_IO(8), .CFG_BITS_PER_IO(3)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .cfg_en                (cfg_en),
    .cfg_head              (cfg_head),
    .cfg_tail              (cfg_tail),
    .cfg_done              (cfg_done),
    .cfg_err               (cfg_err),
    .gfpga_pad_GPIO_PAD_in (pad_in),
    .gfpga_pad_GPIO_PAD_out(pad_out),
    .gfpga_pad_GPIO_PAD_oe (pad_oe),
    .io_outpad             (io_outpad),
    .io_inpad              (io_inpad)
  );

  always #5 clk = ~clk;

  // Expected observation: {done, err, tail, oe[7:0], inpad[7:0], out[7:0]}
  typedef struct {
    string       name;
    logic [26:0] exp;
  } item_t;

  item_t q[$];
  int    n_total = 0;
  int    n_pass  = 0;

  function automatic logic [26:0] pk(input logic done, input logic err,
                                     input logic tail, input logic [7:0] oe,
                                     input logic [7:0] inp, input logic [7:0] outp);
    return {done, err, tail, oe, inp, outp};
  endfunction

  // Monitor: each falling edge, compare every queued expectation with the
  // outputs the DUT presents in that cycle.
  always @(negedge clk) begin
    logic [26:0] act;
    item_t       it;
    act = {cfg_done, cfg_err, cfg_tail, pad_oe, io_inpad, pad_out};
    while (q.size() > 0) begin
      it = q.pop_front();
      n_total++;
      if (act === it.exp) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got done=%b err=%b tail=%b oe=%h inpad=%h out=%h, want done=%b err=%b tail=%b oe=%h inpad=%h out=%h",
                 it.name, act[26], act[25], act[24], act[23:16], act[15:8], act[7:0],
                 it.exp[26], it.exp[25], it.exp[24], it.exp[23:16], it.exp[15:8], it.exp[7:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue an expectation for the current cycle, then advance one clock.
  task automatic chk(input string name, input logic [26:0] exp);
    item_t it;
    it.name = name;
    it.exp  = exp;
    q.push_back(it);
    step();
  endtask

  // Shift the n low bits of w, MSB first, so w[0] ends in chain[0].
  // cfg_en is left high; the caller lowers it.
  task automatic shift_bits(input logic [31:0] w, input int n);
    for (int k = n - 1; k >= 0; k--) begin
      cfg_en   = 1'b1;
      cfg_head = w[k];
      step();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_en    = 1'b0;
    cfg_head  = 1'b0;
    pad_in    = 8'h00;
    io_outpad = 8'h00;
    step();
    step();
    rst_n     = 1'b1;
    io_outpad = 8'h3C;
    chk("reset_state", pk(0, 0, 0, 8'h00, 8'h00, 8'h3C));

    // All-zero configuration: inputs pass straight through
    shift_bits(32'h0, 24);
    cfg_en = 1'b0;
    pad_in = 8'hA5;
    chk("zero_cfg_a5", pk(1, 0, 0, 8'h00, 8'hA5, 8'h3C));
    pad_in = 8'h5A;
    chk("zero_cfg_5a", pk(1, 0, 0, 8'h00, 8'h5A, 8'h3C));

    // Subtile 0: output, registered out path
    io_outpad = 8'h00;
    shift_bits(32'h000005, 24);
    cfg_en = 1'b0;
    chk("sub0_out_loaded", pk(1, 0, 0, 8'h01, 8'h5A, 8'h00));
    io_outpad = 8'hFF;
    chk("sub0_out_same_cycle", pk(1, 0, 0, 8'h01, 8'h5A, 8'hFE));
    chk("sub0_out_next_cycle", pk(1, 0, 0, 8'h01, 8'h5A, 8'hFF));

    // Subtile 3: input, registered in path
    io_outpad = 8'h00;
    pad_in    = 8'h00;
    shift_bits(32'h000400, 24);
    cfg_en = 1'b0;
    chk("sub3_in_loaded", pk(1, 0, 0, 8'h00, 8'h00, 8'h00));
    pad_in = 8'h08;
    chk("sub3_in_same_cycle", pk(1, 0, 0, 8'h00, 8'h00, 8'h00));
    chk("sub3_in_next_cycle", pk(1, 0, 0, 8'h00, 8'h08, 8'h00));

    // Reload pulse after a good load drops to safe state at once
    shift_bits(32'h800001, 24);
    cfg_en = 1'b0;
    chk("tail_loaded", pk(1, 0, 1, 8'h01, 8'h08, 8'h00));
    cfg_en   = 1'b1;
    cfg_head = 1'b0;
    chk("reload_safe", pk(0, 0, 1, 8'h00, 8'h00, 8'h00));
    cfg_en = 1'b0;
    chk("reload_count1", pk(0, 0, 0, 8'h00, 8'h00, 8'h00));

    // Overlong session, then a correct one clears the error
    shift_bits(32'h1000001, 25);
    cfg_en = 1'b0;
    chk("overlong_err", pk(0, 1, 0, 8'h00, 8'h00, 8'h00));
    shift_bits(32'h0, 24);
    cfg_en = 1'b0;
    chk("err_cleared", pk(1, 0, 0, 8'h00, 8'h08, 8'h00));

    // Reset in the middle of a session aborts it
    pad_in = 8'hFF;
    shift_bits(32'hFFFFFFFF, 10);
    chk("mid_session_safe", pk(0, 0, 0, 8'h00, 8'h00, 8'h00));
    rst_n = 1'b0;
    step();
    rst_n     = 1'b1;
    cfg_en    = 1'b0;
    cfg_head  = 1'b0;
    io_outpad = 8'h01;
    chk("mid_reset_state", pk(0, 0, 0, 8'h00, 8'h00, 8'h01));
    shift_bits(32'hFFFFFFFF, 14);
    cfg_en = 1'b0;
    chk("short_session", pk(0, 0, 0, 8'h00, 8'h00, 8'h01));

    // Let the monitor drain, with a bounded wait
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/grid_io_cfg_tile.md
GRID_IO_CFG_TILE -- requirements
Module: grid_io_cfg_tile

Interface
REQ-001 The module SHALL have parameter NUM_IO, default 8, giving the number of IO subtiles (legal range 1..64).
REQ-002 The module SHALL have parameter CFG_BITS_PER_IO, fixed at 3, giving the configuration bits per subtile; CFG_BITS = 3*NUM_IO.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The module SHALL have port cfg_en, input, 1 bit: configuration shift enable.
REQ-006 The module SHALL have port cfg_head, input, 1 bit: serial configuration data in.
REQ-007 The module SHALL have port cfg_tail, output, 1 bit: serial configuration data out, chain[CFG_BITS-1].
REQ-008 The module SHALL have port cfg_done, output, 1 bit: a complete, exact-length configuration is loaded and active.
REQ-009 The module SHALL have port cfg_err, output, 1 bit: the last load session shifted more than CFG_BITS bits.
REQ-010 The module SHALL have port gfpga_pad_GPIO_PAD_in, input, NUM_IO bits: pad receive data.
REQ-011 The module SHALL have port gfpga_pad_GPIO_PAD_out, output, NUM_IO bits: pad drive data.
REQ-012 The module SHALL have port gfpga_pad_GPIO_PAD_oe, output, NUM_IO bits: pad output enable, active-high.
REQ-013 The module SHALL have port io_outpad, input, NUM_IO bits: fabric-to-pad data, one bit per subtile.
REQ-014 The module SHALL have port io_inpad, output, NUM_IO bits: pad-to-fabric data, one bit per subtile.

Function
REQ-015 The module SHALL hold a CFG_BITS shift chain; each cycle with cfg_en=1: chain[0]<=cfg_head and chain[k]<=chain[k-1]; with cfg_en=0 the chain holds.
REQ-016 The module SHALL map subtile i to chain[3i] = oe_mode, chain[3i+1] = in_reg, chain[3i+2] = out_reg.
REQ-017 The module SHALL keep a shift counter saturating at CFG_BITS+1: it loads 1 on the first cfg_en=1 cycle after a cfg_en=0 cycle (session start) and increments on each further cfg_en=1 cycle.
REQ-018 The module SHALL drive cfg_done=1 exactly when cfg_en=0 and counter==CFG_BITS; cfg_done SHALL drop combinationally as soon as cfg_en rises.
REQ-019 The module SHALL drive cfg_err=1 when counter==CFG_BITS+1 and SHALL clear it at the next session start or on reset.
REQ-020 A short session (counter<CFG_BITS) SHALL leave cfg_done=0 and cfg_err=0.
REQ-021 The module SHALL register io_outpad into out_q[i] and gfpga_pad_GPIO_PAD_in into in_q[i] every cycle, independent of configuration.
REQ-022 gfpga_pad_GPIO_PAD_out[i] SHALL equal out_q[i] if out_reg=1, else io_outpad[i]; latency 1 cycle or 0 cycles respectively.
REQ-023 gfpga_pad_GPIO_PAD_oe[i] SHALL equal cfg_done AND oe_mode[i].
REQ-024 io_inpad[i] SHALL equal cfg_done AND NOT oe_mode[i] AND (in_reg ? in_q[i] : gfpga_pad_GPIO_PAD_in[i]).
REQ-025 Consequently, while cfg_en=1 or the configuration is incomplete or erroneous, all oe SHALL be 0 and all io_inpad SHALL be 0 (safe state).
REQ-026 With cfg_en=1 and rst_n=0 in the same cycle, reset SHALL win.

Reset
REQ-027 While rst_n=0 at a rising clk edge, chain, counter, out_q and in_q SHALL become 0 and session state SHALL mark "previous cfg_en=0".
REQ-028 After reset: cfg_tail=0, cfg_done=0, cfg_err=0, all oe=0, all io_inpad=0, and gfpga_pad_GPIO_PAD_out=io_outpad (out_reg=0).
REQ-029 Reset asserted mid-session SHALL abort the load; a new full CFG_BITS session is required for cfg_done.

Verification (NUM_IO=8, CFG_BITS=24)
REQ-030 Reset then 24 shifts of all-zero, cfg_en low -> cfg_done=1, cfg_err=0, oe=0x00, io_inpad follows pad_in combinationally (pad_in=0xA5 -> io_inpad=0xA5 same cycle).
REQ-031 24 shifts with the last three bits shifted being out_reg=1, in_reg=0, oe_mode=1 (subtile 0), all others 0 -> oe=0x01 (bit 0); io_outpad[0] toggled 0->1 appears on pad_out[0] one cycle later; io_inpad[0]=0.
REQ-032 Subtile 3 in_reg=1, oe_mode=0 -> pad_in[3] 0->1 appears on io_inpad[3] one cycle later.
REQ-033 25 shifts -> cfg_err=1, cfg_done=0, oe=0x00; a following 24-shift session -> cfg_err=0, cfg_done=1.
REQ-034 Raise cfg_en for 1 cycle after cfg_done=1 -> oe and io_inpad go to 0 in that cycle; cfg_done stays 0 (counter=1); cfg_tail equals the bit shifted in 24 shifts earlier.
REQ-035 Assert rst_n=0 after 10 of 24 shifts -> all outputs return to the reset values of REQ-028; 14 further shifts do not set cfg_done.
